// File: rtl/coin_if.sv
// coin_if: coin sensor inputs and classified coin outputs between chute and vending FSM
interface coin_if;
  logic       coin_sense;
  logic       accept_en;
  logic [1:0] coin;
  logic       reject;
  logic       jam;
  logic       busy;
  modport master (output coin_sense, accept_en, input coin, reject, jam, busy);
  modport slave (input coin_sense, accept_en, output coin, reject, jam, busy);
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises the chute sensor, measures pulse width and classifies Rs5/Rs10 coins
module coin_acceptor #(
  parameter int W_BITS     = 8,
  parameter int GLITCH_MAX = 3,
  parameter int W5_MIN     = 10,
  parameter int W5_MAX     = 20,
  parameter int W10_MIN    = 30,
  parameter int W10_MAX    = 45,
  parameter int JAM_CYC    = 200,
  parameter int GAP_CYC    = 8
) (
  input logic   clk,
  input logic   rst,
  coin_if.slave bus
);
  localparam logic [W_BITS-1:0] L_GL  = W_BITS'(GLITCH_MAX);
  localparam logic [W_BITS-1:0] L_5L  = W_BITS'(W5_MIN);
  localparam logic [W_BITS-1:0] L_5H  = W_BITS'(W5_MAX);
  localparam logic [W_BITS-1:0] L_10L = W_BITS'(W10_MIN);
  localparam logic [W_BITS-1:0] L_10H = W_BITS'(W10_MAX);
  localparam logic [W_BITS-1:0] L_JAM = W_BITS'(JAM_CYC);
  localparam logic [W_BITS-1:0] L_GAP = W_BITS'(GAP_CYC - 1);
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKOUT, JAM} state_t;
  state_t            state, state_n;
  logic              s1, s;
  logic [W_BITS-1:0] width, width_n, gap, gap_n;
  logic [1:0]        coin_n;
  logic              reject_n, v5, v10;
  assign v5       = width >= L_5L && width <= L_5H;
  assign v10      = width >= L_10L && width <= L_10H;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s          <= 1'b0;
      state      <= IDLE;
      width      <= '0;
      gap        <= '0;
      bus.coin   <= 2'b00;
      bus.reject <= 1'b0;
      bus.jam    <= 1'b0;
    end else begin
      s1         <= bus.coin_sense;
      s          <= s1;
      state      <= state_n;
      width      <= width_n;
      gap        <= gap_n;
      bus.coin   <= coin_n;
      bus.reject <= reject_n;
      bus.jam    <= state_n == JAM;
    end
  end
  always_comb begin
    state_n  = state;
    width_n  = width;
    gap_n    = gap;
    coin_n   = 2'b00;
    reject_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = s ? MEASURE : IDLE;
        width_n = s ? W_BITS'(1) : width;
      end
      MEASURE: begin
        if (s) begin
          width_n = width == L_JAM ? width : width + W_BITS'(1);
          state_n = width_n == L_JAM ? JAM : MEASURE;
        end else begin
          // widths at or below the glitch limit vanish without any output
          state_n  = LOCKOUT;
          gap_n    = '0;
          coin_n   = (width > L_GL && bus.accept_en) ? {v10, v5} : 2'b00;
          reject_n = width > L_GL && !(bus.accept_en && (v5 || v10));
        end
      end
      default: begin
        gap_n   = s ? '0 : gap + W_BITS'(1);
        state_n = (!s && gap == L_GAP) ? IDLE : state;
      end
    endcase
  end
endmodule
